// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, flag bit indices and sequencer state encoding shared
//               by the ALU front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FLG_AZERO  = 0;
  localparam int FLG_AONES  = 1;
  localparam int FLG_AMSB   = 2;
  localparam int FLG_ALSB   = 3;
  localparam int FLG_CARRY  = 4;
  localparam int FLG_BORROW = 5;
  localparam int FLG_RZERO  = 6;
  localparam int FLG_RONES  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Command/response front-end for the combinational 8-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_acc,
  input  logic [WIDTH-1:0] alu_mulh,
  input  logic [7:0]       alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_acc,
  output logic [WIDTH-1:0] rsp_mulh,
  output logic [7:0]       rsp_flag,
  output logic [15:0]      op_count,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_s;
  logic [WIDTH-1:0] r_rsp_acc;
  logic [WIDTH-1:0] r_rsp_mulh;
  logic [7:0]       r_rsp_flag;
  logic [15:0]      r_op_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_s    <= '0;
      r_rsp_acc  <= '0;
      r_rsp_mulh <= '0;
      r_rsp_flag <= '0;
      r_op_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && cmd_valid) begin
        r_alu_s <= cmd_op;
        r_alu_b <= cmd_b;
        r_alu_a <= cmd_chain ? r_rsp_acc : cmd_a;
      end
      // ALU inputs have been stable for a full cycle when we sample here
      if (r_state == ST_EXEC) begin
        r_rsp_acc  <= alu_acc;
        r_rsp_flag <= alu_flag;
        r_rsp_mulh <= (r_alu_s == OP_MUL) ? alu_mulh : '0;
      end
      if (r_state == ST_RESP && rsp_ready) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  // Held low while rst is asserted so a coincident command is never acknowledged
  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign rsp_acc   = r_rsp_acc;
  assign rsp_mulh  = r_rsp_mulh;
  assign rsp_flag  = r_rsp_flag;
  assign op_count  = r_op_count;

endmodule

`default_nettype wire
